// File: rtl/mfcc_melbank_accum.sv
// Mel filterbank accumulator: weighted power bins into N_FILT saturating sums.
// Define MFCC_MELBANK_ROM_OUT_REG_EN for a ROM with one cycle of read latency.
module mfcc_melbank_accum #(
  parameter int N_BINS = 256,
  parameter int N_FILT = 26,
  parameter int IN_W   = 32,
  parameter int ACC_W  = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic [8:0]       rom_addr,
  input  logic [7:0]       rom_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [4:0]       out_idx,
  output logic             out_last,
  output logic             busy
);

`ifdef MFCC_MELBANK_ROM_OUT_REG_EN
  localparam bit ROM_REG = 1'b1;
`else
  localparam bit ROM_REG = 1'b0;
`endif

  localparam int PW = IN_W + 8;
  localparam int SW = (ACC_W > PW ? ACC_W : PW) + 1;
  localparam logic [SW-1:0] SAT = SW'({ACC_W{1'b1}});
  localparam logic [7:0] LAST_BIN = 8'(N_BINS - 1);
  localparam logic [4:0] NF5 = 5'(N_FILT);

  typedef enum logic [2:0] {
    S_IDLE, S_RDW, S_RDM, S_ACC, S_OUT
  } state_t;

  state_t state, state_nxt;
  logic             ph, ph_nxt;
  logic             rd_done;
  logic [7:0]       bin_cnt;
  logic [IN_W-1:0]  p_q;
  logic [7:0]       w_q;
  logic [4:0]       m_q;
  logic [8:0]       rom_addr_q;
  logic [ACC_W-1:0] acc [N_FILT];
  logic [PW-1:0]    prod_up, prod_lo;
  logic             up_en, lo_en;

  function automatic logic [ACC_W-1:0] sat_add(
    input logic [ACC_W-1:0] a,
    input logic [PW-1:0]    b
  );
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return (s > SAT) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  // With a registered ROM each read state spends one extra cycle waiting
  assign rd_done = !ROM_REG || ph;
  assign prod_up = PW'(p_q) * PW'(w_q);
  assign prod_lo = PW'(p_q) * PW'(8'd255 - w_q);
  assign up_en   = m_q < NF5;
  assign lo_en   = m_q != 5'd0;
  assign busy    = state != S_IDLE;

  always_comb begin
    state_nxt = state;
    ph_nxt    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rom_addr  = rom_addr_q;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_RDW;
      end
      S_RDW: begin
        rom_addr = {1'b0, bin_cnt};
        ph_nxt   = !rd_done;
        if (rd_done) state_nxt = S_RDM;
      end
      S_RDM: begin
        rom_addr = {1'b1, bin_cnt};
        ph_nxt   = !rd_done;
        if (rd_done) state_nxt = S_ACC;
      end
      S_ACC: begin
        state_nxt = (bin_cnt == LAST_BIN) ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready && out_idx == NF5 - 5'd1)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    out_last = out_valid && (out_idx == NF5 - 5'd1);
    out_data = out_valid ? acc[out_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ph         <= 1'b0;
      bin_cnt    <= '0;
      p_q        <= '0;
      w_q        <= '0;
      m_q        <= '0;
      out_idx    <= '0;
      rom_addr_q <= '0;
      for (int i = 0; i < N_FILT; i++) acc[i] <= '0;
    end else begin
      state      <= state_nxt;
      ph         <= ph_nxt;
      rom_addr_q <= rom_addr;
      if (in_valid && in_ready) p_q <= in_data;
      if (state == S_RDW && rd_done) w_q <= rom_rd_data;
      // Indices past the last filter behave as N_FILT
      if (state == S_RDM && rd_done)
        m_q <= (rom_rd_data > 8'(N_FILT)) ? NF5 : rom_rd_data[4:0];
      if (state == S_ACC) begin
        if (bin_cnt != LAST_BIN) bin_cnt <= bin_cnt + 8'd1;
        for (int i = 0; i < N_FILT; i++) begin
          if (up_en && m_q == 5'(i))
            acc[i] <= sat_add(acc[i], prod_up);
          else if (lo_en && m_q == 5'(i + 1))
            acc[i] <= sat_add(acc[i], prod_lo);
        end
      end
      if (out_valid && out_ready) begin
        if (out_last) begin
          out_idx <= '0;
          bin_cnt <= '0;
          for (int i = 0; i < N_FILT; i++) acc[i] <= '0;
        end else begin
          out_idx <= out_idx + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mfcc_melbank_accum.sv
// Bench for mfcc_melbank_accum: two instances (ACC_W 48 and 40) in lockstep.
// Expected energies come from a per-frame arithmetic model of the ROM map.
module tb_mfcc_melbank_accum;
  localparam int NB = 256;
  localparam int NF = 26;
`ifdef MFCC_MELBANK_ROM_OUT_REG_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif
  localparam longint MAX48 = 64'h0000_FFFF_FFFF_FFFF;
  localparam longint MAX40 = 64'h0000_00FF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready_a, in_ready_b, ov_a, ov_b, ol_a, ol_b, busy_a, busy_b;
  logic [8:0] ra_a, ra_b;
  logic [7:0] rd_a, rd_b;
  logic [47:0] od_a;
  logic [39:0] od_b;
  logic [4:0] oi_a, oi_b;

  logic [7:0] rom_w [NB];
  logic [7:0] rom_m [NB];
  logic [31:0] pw [NB];
  longint e48 [NF];
  longint e40 [NF];
  bit pat [4];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  typedef struct {
    int bin; int w; int m; longint p;
    int ia; longint va; int ib; longint vb;
  } vec_t;
  vec_t tv [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MFCC_MELBANK_ROM_OUT_REG_EN
  always @(posedge clk) begin
    rd_a <= ra_a[8] ? rom_m[ra_a[7:0]] : rom_w[ra_a[7:0]];
    rd_b <= ra_b[8] ? rom_m[ra_b[7:0]] : rom_w[ra_b[7:0]];
  end
`else
  always_comb begin
    rd_a = ra_a[8] ? rom_m[ra_a[7:0]] : rom_w[ra_a[7:0]];
    rd_b = ra_b[8] ? rom_m[ra_b[7:0]] : rom_w[ra_b[7:0]];
  end
`endif

  mfcc_melbank_accum #(.ACC_W(48)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .rom_addr(ra_a), .rom_rd_data(rd_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
    .out_idx(oi_a), .out_last(ol_a), .busy(busy_a)
  );

  mfcc_melbank_accum #(.ACC_W(40)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .rom_addr(ra_b), .rom_rd_data(rd_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
    .out_idx(oi_b), .out_last(ol_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model();
    longint s [NF];
    int m;
    longint p, w;
    for (int i = 0; i < NF; i++) s[i] = 0;
    for (int b = 0; b < NB; b++) begin
      m = (int'(rom_m[b]) > NF) ? NF : int'(rom_m[b]);
      p = longint'(pw[b]);
      w = longint'(rom_w[b]);
      if (m < NF) s[m] += p * w;
      if (m >= 1) s[m-1] += p * (255 - w);
    end
    for (int i = 0; i < NF; i++) begin
      e48[i] = (s[i] > MAX48) ? MAX48 : s[i];
      e40[i] = (s[i] > MAX40) ? MAX40 : s[i];
    end
  endtask

  task automatic feed(input int nb, output int last_hs);
    int prev, bad, g;
    prev = -1;
    bad = 0;
    for (int b = 0; b < nb; b++) begin
      g = 0;
      in_valid = 1'b1;
      in_data = pw[b];
      while (!in_ready_a && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (g >= 20) bad++;
      if (in_ready_b !== in_ready_a) bad++;
      @(negedge clk);
      in_valid = 1'b0;
      if (ra_a !== {1'b0, 8'(b)} || ra_b !== ra_a) bad++;
      if (prev >= 0 && cyc - prev != LAT) bad++;
      prev = cyc;
    end
    last_hs = prev;
    chk("feed_timing", 64'(bad), 64'd0);
  endtask

  task automatic drain(input bit bp, input int exp_first);
    int n, k, g;
    bit stalled, seen;
    logic [47:0] hd;
    logic [4:0] hi;
    n = 0; k = 0; g = 0;
    stalled = 1'b0;
    seen = 1'b0;
    hd = '0;
    hi = '0;
    while (n < NF && g < 500) begin
      if (ov_a) begin
        if (!seen) begin
          seen = 1'b1;
          chk("first_valid_cycle", 64'(cyc), 64'(exp_first));
          chk("busy_drain", 64'(busy_a), 64'd1);
        end
        if (stalled) begin
          chk("hold_data", 64'(od_a), 64'(hd));
          chk("hold_idx", 64'(oi_a), 64'(hi));
        end
        chk("in_ready_drain", 64'(in_ready_a), 64'd0);
        out_ready = bp ? pat[k % 4] : 1'b1;
        k++;
        if (out_ready) begin
          chk($sformatf("idx[%0d]", n), 64'(oi_a), 64'(n));
          chk($sformatf("e48[%0d]", n), 64'(od_a), 64'(e48[n]));
          chk($sformatf("e40[%0d]", n), 64'(od_b), 64'(e40[n]));
          chk($sformatf("last[%0d]", n), 64'(ol_a), 64'(n == NF - 1));
          chk($sformatf("lockstep[%0d]", n),
              64'({ov_b, ol_b, oi_b}), 64'({1'b1, ol_a, oi_a}));
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hd = od_a;
          hi = oi_a;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    out_ready = 1'b0;
    chk("handshakes", 64'(n), 64'(NF));
    chk("valid_after", 64'(ov_a), 64'd0);
    chk("in_ready_after", 64'(in_ready_a), 64'd1);
    chk("busy_after", 64'(busy_a), 64'd0);
  endtask

  task automatic run_frame(input bit bp);
    int last_hs;
    feed(NB, last_hs);
    drain(bp, last_hs + LAT - 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready_a), 64'd1);
    chk({tag, "_busy"}, 64'({busy_a, busy_b}), 64'd0);
    chk({tag, "_rom_addr"}, 64'(ra_a), 64'd0);
    chk({tag, "_out_valid"}, 64'({ov_a, ov_b}), 64'd0);
    chk({tag, "_out_data"}, 64'(od_a), 64'd0);
    chk({tag, "_out_idx"}, 64'(oi_a), 64'd0);
    chk({tag, "_out_last"}, 64'(ol_a), 64'd0);
  endtask

  task automatic rand_frame();
    for (int b = 0; b < NB; b++) begin
      rom_w[b] = 8'($urandom_range(0, 255));
      rom_m[b] = 8'($urandom_range(0, 31));
      pw[b] = $urandom;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int last_hs;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    tv[0] = '{0,   200, 0,  10,   0,  2000,   31, 0};
    tv[1] = '{5,   100, 3,  1000, 3,  100000, 2,  155000};
    tv[2] = '{255, 0,   26, 7,    25, 1785,   31, 0};
    tv[3] = '{17,  255, 31, 4,    31, 0,      31, 0};
    tv[4] = '{200, 50,  25, 3,    25, 150,    24, 615};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("reset");

    for (int t = 0; t < 5; t++) begin
      for (int b = 0; b < NB; b++) begin
        rom_w[b] = 8'd0;
        rom_m[b] = 8'(NF);
        pw[b] = 32'd0;
      end
      rom_w[tv[t].bin] = 8'(tv[t].w);
      rom_m[tv[t].bin] = 8'(tv[t].m);
      pw[tv[t].bin] = 32'(tv[t].p);
      for (int i = 0; i < NF; i++) begin
        e48[i] = 0;
        e40[i] = 0;
      end
      if (tv[t].ia < NF) begin
        e48[tv[t].ia] = tv[t].va;
        e40[tv[t].ia] = tv[t].va;
      end
      if (tv[t].ib < NF) begin
        e48[tv[t].ib] = tv[t].vb;
        e40[tv[t].ib] = tv[t].vb;
      end
      run_frame(1'b0);
    end

    rand_frame();
    model();
    run_frame(1'b0);

    rand_frame();
    model();
    run_frame(1'b1);

    for (int b = 0; b < NB; b++) begin
      rom_w[b] = 8'd255;
      rom_m[b] = 8'd0;
      pw[b] = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < NF; i++) begin
      e48[i] = 0;
      e40[i] = 0;
    end
    e48[0] = 64'd280375465017600;
    e40[0] = MAX40;
    run_frame(1'b0);

    rand_frame();
    feed(101, last_hs);
    repeat (LAT == 6 ? 2 : 1) @(negedge clk);
    chk("rdm_addr_bin100", 64'(ra_a), 64'h164);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midframe");
    rst = 1'b0;
    for (int b = 0; b < NB; b++) pw[b] = $urandom;
    model();
    run_frame(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mfcc_melbank_accum.md
# mfcc_melbank_accum

Mel filterbank accumulator for the MFCC front end. It takes one frame of power-spectrum bins as a stream and drives the address port of the 512×8 mel-bank ROM. For each bin it reads a weight and a filter index, then adds the weighted power into two adjacent triangular-filter accumulators. At end of frame it streams out the N_FILT filter energies toward the log/DCT stage.

## Interface
- N_BINS, 256: power-spectrum bins per frame; the bin index is 8 bits.
- N_FILT, 26: number of mel filters, maximum 31.
- IN_W, 32: unsigned power sample width.
- ACC_W, 48: accumulator and output width.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  power sample valid.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- in_data  in  IN_W  unsigned power of the current bin; bins arrive in order 0..N_BINS-1.
- rom_addr  out  9  mel-bank ROM address.
- rom_rd_data  in  8  mel-bank ROM data.
- out_valid  out  1  filter energy valid.
- out_ready  in  1  downstream accept.
- out_data  out  ACC_W  filter energy.
- out_idx  out  5  filter index, 0..N_FILT-1.
- out_last  out  1  high with out_idx == N_FILT-1.
- busy  out  1  high in any state except S_IDLE.

## Operation
- ROM map: address {1'b0,bin} holds weight w (0..255); address {1'b1,bin} holds upper filter index m (0..N_FILT).
- Bin contribution, with p = in_data:
  - acc[m] += p*w, only if m < N_FILT.
  - acc[m-1] += p*(255-w), only if m >= 1.
  - Both updates happen in the same cycle.
- m > N_FILT is treated as m = N_FILT: the upper add is skipped and the lower add goes to N_FILT-1.
- Accumulators saturate at 2^ACC_W-1 and never wrap. The products are IN_W+8 bits, zero-extended.
- States and transitions:
  - S_IDLE: in_ready=1. On handshake, latch p and bin_cnt, then go to S_RDW.
  - S_RDW: rom_addr={0,bin}; latch w. Go to S_RDM.
  - S_RDM: rom_addr={1,bin}; latch m. Go to S_ACC.
  - S_ACC: update the accumulators. If bin_cnt==N_BINS-1 go to S_OUT, else increment bin_cnt and go to S_IDLE.
  - S_OUT: out_valid=1 and out_data=acc[out_idx]. out_idx advances on each out handshake. On the handshake with out_last, all accumulators and bin_cnt clear and the state goes to S_IDLE.
- in_ready is 0 outside S_IDLE. No new frame is accepted while S_OUT drains.
- out_valid, out_data and out_idx hold stable while out_valid && !out_ready.

## Timing
- Reset values:
  - state S_IDLE, in_ready 1, busy 0.
  - rom_addr 0, out_valid 0, out_data 0, out_idx 0, out_last 0.
  - all accumulators 0, bin_cnt 0.
- The ROM is combinational by default: rom_rd_data is sampled in the same cycle rom_addr is driven.
- Per bin: handshake at cycle T, S_RDW at T+1, S_RDM at T+2, S_ACC at T+3, in_ready high again at T+4. Throughput is 1 bin per 4 cycles.
- The first out_valid comes in the cycle after S_ACC of bin N_BINS-1. With out_ready held high, the drain takes N_FILT cycles.
- rom_addr holds its last value outside S_RDW and S_RDM.
- rst during any state returns all outputs to their reset values on the next edge and discards the partial frame. No output handshake completes in the reset cycle.

## Configuration
- MFCC_MELBANK_ROM_OUT_REG_EN:
  - Defined: the ROM is built with a registered output, one cycle of latency. S_RDW and S_RDM each last 2 cycles: the address is driven in the first cycle and data is sampled in the second. The address stays held across both cycles.
  - Per-bin cycle: 6 cycles, with in_ready high again at T+6.
  - Undefined: the 4-cycle combinational timing above applies.
  - Both variants produce identical out_data.

## Test plan
- Single contribution: ROM bin0 has w=200, m=0, every other bin has w=0, m=N_FILT. Bin0 p=10, others p=0. Response: acc[0]=2000; all other outputs 0; out_last on idx 25.
- Split across two filters: bin5 has w=100, m=3, p=1000. Response: acc[3]=100000, acc[2]=155000.
- Saturation: ACC_W=40. Every bin has w=255, m=0, p=2^32-1. Response: acc[0]=2^40-1; acc[1] through acc[N_FILT-1]=0.
- Backpressure: out_ready toggles 1,0,0,1 during the drain. Response: out_data and out_idx stay stable during stalls; exactly 26 handshakes; in_ready stays 0 until after the out_last handshake.
- Reset mid-frame: assert rst in S_RDM of bin 100, then run a full frame. Response: outputs are computed from the new frame only, with no residue from bins 0..100.
- Macro variant: the same stimulus as the split test with MFCC_MELBANK_ROM_OUT_REG_EN defined and a 1-cycle ROM model. Response: identical energies; handshake spacing of 6 cycles.
